// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RISC-V control sequencer with memory handshake
// Optional retired-instruction counter built when MCFSM_INSTRET_EN is defined.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        illegal_op,
    output logic        mem_err
`ifdef MCFSM_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       pc_we;
        logic       reg_we;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    // Moore control word for the state being entered; registered on the transition edge.
    function automatic ctrl_t ctrl_of(input state_t s, input logic is_jalr, input logic is_link);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            S_WB_ALU: begin
                c.reg_we = 1'b1;
                if (is_link) begin
                    c.alu_src_a = 2'b01;
                    c.alu_src_b = 2'b10;
                end
            end
            S_WB_MEM: begin
                c.reg_we     = 1'b1;
                c.result_src = 2'b01;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            S_JUMP: begin
                c.pc_we = 1'b1;
                if (is_jalr) begin
                    c.alu_src_a  = 2'b10;
                    c.alu_src_b  = 2'b01;
                    c.result_src = 2'b10;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    logic       r_run;
    logic       r_illegal;
    logic       r_mem_err;
    logic [7:0] r_wait;
    logic       w_in_mem;
    logic       w_timeout;
    logic       w_fetch_done;
    logic       w_branch_take;
    logic       w_retire;

    always_comb begin
        w_in_mem      = r_run && (r_state == S_FETCH || r_state == S_MEM_RD || r_state == S_MEM_WR);
        w_timeout     = w_in_mem && !mem_ready && (r_wait == WAIT_LAST);
        w_fetch_done  = r_run && (r_state == S_FETCH) && mem_ready;
        w_branch_take = (r_state == S_BRANCH) && (funct3[0] ? !zero : zero);
        w_retire      = (r_state == S_WB_ALU) || (r_state == S_WB_MEM) || (r_state == S_BRANCH) ||
                        ((r_state == S_MEM_WR) && mem_ready);
        w_next        = r_state;
        // The first cycle out of reset only loads the FETCH control word.
        if (!r_run) begin
            w_next = S_FETCH;
        end else if (w_timeout) begin
            w_next = S_TRAP;
        end else begin
            case (r_state)
                S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_R:              w_next = S_EXEC_R;
                        OP_I:              w_next = S_EXEC_I;
                        OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                        OP_BRANCH:         w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                        OP_JAL, OP_JALR:   w_next = S_JUMP;
                        default:           w_next = S_TRAP;
                    endcase
                end
                S_EXEC_R:   w_next = S_WB_ALU;
                S_EXEC_I:   w_next = S_WB_ALU;
                S_MEM_ADDR: w_next = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
                S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
                S_WB_ALU:   w_next = S_FETCH;
                S_WB_MEM:   w_next = S_FETCH;
                S_BRANCH:   w_next = S_FETCH;
                S_JUMP:     w_next = S_WB_ALU;
                default:    w_next = S_TRAP;
            endcase
        end
    end

`ifdef MCFSM_INSTRET_EN
    logic [31:0] r_instret;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= '0;
            r_run     <= 1'b0;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
`ifdef MCFSM_INSTRET_EN
            r_instret <= '0;
`endif
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next, op == OP_JALR, r_state == S_JUMP);
            r_wait  <= (w_in_mem && !mem_ready) ? r_wait + 8'd1 : 8'd0;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
`ifdef MCFSM_INSTRET_EN
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
`endif
        end
    end

    assign mem_req    = r_ctrl.mem_req;
    assign mem_we     = r_ctrl.mem_we;
    assign adr_src    = r_ctrl.adr_src;
    assign reg_we     = r_ctrl.reg_we;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_op     = r_ctrl.alu_op;
    assign result_src = r_ctrl.result_src;
    assign ir_we      = w_fetch_done;
    assign pc_we      = r_ctrl.pc_we | w_fetch_done | w_branch_take;
    assign illegal_op = r_illegal;
    assign mem_err    = r_mem_err;
`ifdef MCFSM_INSTRET_EN
    assign instret    = r_instret;
`else
    logic w_unused;
    assign w_unused = w_retire;
`endif

endmodule
